// File: rtl/sram_bus_arbiter.sv
// sram_bus_arbiter: shares one 32-bit asynchronous SRAM between instruction
// fetch (IF) and data access (MEM) with a req/done handshake.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise MEM has fixed priority over IF.
//
// state        | meaning
// S_IDLE       | strobes released, waiting for a request to grant
// S_RD         | ce_n/oe_n low for RD_WAIT cycles, data captured in the last one
// S_WR_SETUP   | address, byte enables and data driven before we_n falls
// S_WR_PULSE   | we_n low for WR_PULSE cycles
// S_DONE       | one-cycle done pulse; write data held for hold time
module sram_bus_arbiter #(
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1,
    parameter int ADDR_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic              mem_byte,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    output logic              sram_data_oe,
    input  logic [31:0]       sram_rdata,
    output logic [3:0]        sram_be_n,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_DONE} state_t;

    state_t            state, state_next;
    logic [2:0]        cnt, cnt_next;
    logic              gnt_mem, gnt_mem_next;
    logic              op_byte, op_byte_next;
    logic [1:0]        lane, lane_next;
    logic              pick_mem;
    logic [ADDR_W-1:0] addr_next;
    logic [31:0]       wdata_next, if_rdata_next, mem_rdata_next;
    logic [3:0]        be_n_next;
    logic              ce_n_next, oe_n_next, we_n_next, data_oe_next;
    logic              if_done_next, mem_done_next;
    logic [7:0]        rd_byte;
    logic [31:0]       load_word;
    logic              unused_addr_bits;

    // Only the word address inside the SRAM matters; the rest wraps away.
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0], mem_addr[31:ADDR_W+2]};

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last;  // 1 = MEM was granted last

    // Tie goes to whichever port was not served last.
    always_comb begin
        if (mem_req && if_req) pick_mem = !rr_last;
        else                   pick_mem = mem_req;
    end

    // Remember the port of every grant; reset value makes the first tie go to MEM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                      rr_last <= 1'b0;
        else if (state == S_IDLE && (mem_req || if_req)) rr_last <= pick_mem;
    end
`else
    assign pick_mem = mem_req;
`endif

    // Byte lane select and sign extension for LB; words pass through.
    always_comb begin
        case (lane)
            2'd0:    rd_byte = sram_rdata[7:0];
            2'd1:    rd_byte = sram_rdata[15:8];
            2'd2:    rd_byte = sram_rdata[23:16];
            default: rd_byte = sram_rdata[31:24];
        endcase
    end
    assign load_word = op_byte ? {{24{rd_byte[7]}}, rd_byte} : sram_rdata;

    // Next state and next registered output values; strobes default to released.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        gnt_mem_next   = gnt_mem;
        op_byte_next   = op_byte;
        lane_next      = lane;
        addr_next      = sram_addr;
        wdata_next     = sram_wdata;
        be_n_next      = sram_be_n;
        if_rdata_next  = if_rdata;
        mem_rdata_next = mem_rdata;
        ce_n_next      = 1'b1;
        oe_n_next      = 1'b1;
        we_n_next      = 1'b1;
        data_oe_next   = 1'b0;
        if_done_next   = 1'b0;
        mem_done_next  = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_req || if_req) begin
                    gnt_mem_next = pick_mem;
                    ce_n_next    = 1'b0;
                    if (pick_mem) begin
                        op_byte_next = mem_byte;
                        lane_next    = mem_addr[1:0];
                        addr_next    = mem_addr[ADDR_W+1:2];
                        be_n_next    = mem_byte ? ~(4'b0001 << mem_addr[1:0]) : 4'h0;
                    end else begin
                        op_byte_next = 1'b0;
                        lane_next    = 2'd0;
                        addr_next    = if_addr[ADDR_W+1:2];
                        be_n_next    = 4'h0;
                    end
                    if (pick_mem && mem_we) begin
                        wdata_next   = mem_byte ? {4{mem_wdata[7:0]}} : mem_wdata;
                        data_oe_next = 1'b1;
                        cnt_next     = 3'(WR_PULSE - 1);
                        state_next   = S_WR_SETUP;
                    end else begin
                        oe_n_next    = 1'b0;
                        cnt_next     = 3'(RD_WAIT - 1);
                        state_next   = S_RD;
                    end
                end
            end
            S_RD: begin
                if (cnt == 3'd0) begin
                    state_next = S_DONE;
                    if (gnt_mem) begin
                        mem_rdata_next = load_word;
                        mem_done_next  = 1'b1;
                    end else begin
                        if_rdata_next  = sram_rdata;
                        if_done_next   = 1'b1;
                    end
                end else begin
                    ce_n_next = 1'b0;
                    oe_n_next = 1'b0;
                    cnt_next  = cnt - 3'd1;
                end
            end
            S_WR_SETUP: begin
                ce_n_next    = 1'b0;
                data_oe_next = 1'b1;
                we_n_next    = 1'b0;
                state_next   = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                ce_n_next    = 1'b0;
                data_oe_next = 1'b1;
                if (cnt == 3'd0) begin
                    mem_done_next = 1'b1;
                    state_next    = S_DONE;
                end else begin
                    we_n_next = 1'b0;
                    cnt_next  = cnt - 3'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register plus every output register; reset releases strobes at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            gnt_mem      <= 1'b0;
            op_byte      <= 1'b0;
            lane         <= 2'd0;
            sram_addr    <= '0;
            sram_wdata   <= 32'h0;
            sram_be_n    <= 4'hF;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_data_oe <= 1'b0;
            if_rdata     <= 32'h0;
            mem_rdata    <= 32'h0;
            if_done      <= 1'b0;
            mem_done     <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            gnt_mem      <= gnt_mem_next;
            op_byte      <= op_byte_next;
            lane         <= lane_next;
            sram_addr    <= addr_next;
            sram_wdata   <= wdata_next;
            sram_be_n    <= be_n_next;
            sram_ce_n    <= ce_n_next;
            sram_oe_n    <= oe_n_next;
            sram_we_n    <= we_n_next;
            sram_data_oe <= data_oe_next;
            if_rdata     <= if_rdata_next;
            mem_rdata    <= mem_rdata_next;
            if_done      <= if_done_next;
            mem_done     <= mem_done_next;
        end
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed bench for sram_bus_arbiter with default parameters.
module tb_sram_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we, mem_byte;
    logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
    logic [31:0] if_rdata, mem_rdata, sram_wdata;
    logic        if_done, mem_done, sram_data_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [19:0] sram_addr;
    logic [3:0]  sram_be_n;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_data_oe(sram_data_oe),
        .sram_rdata(sram_rdata), .sram_be_n(sram_be_n), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_strobes"}, {28'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe}, 32'hE);
        chk({tag, "_be_n"},    {28'h0, sram_be_n}, 32'hF);
        chk({tag, "_addr"},    {12'h0, sram_addr}, 32'h0);
        chk({tag, "_wdata"},   sram_wdata, 32'h0);
        chk({tag, "_rdata"},   if_rdata | mem_rdata, 32'h0);
        chk({tag, "_done"},    {30'h0, if_done, mem_done}, 32'h0);
    endtask

    // One transaction from the IDLE cycle; observes strobes until done (bounded).
    task automatic run_txn(input logic use_mem, input logic we, input logic byt,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int oe_c, output int we_c,
                           output logic [3:0] be_s, output logic [31:0] wd_s,
                           output logic [19:0] ad_s);
        lat = 0; oe_c = 0; we_c = 0; be_s = 4'hF; wd_s = 32'h0; ad_s = 20'h0;
        @(negedge clk);
        if (use_mem) begin
            mem_req = 1'b1; mem_we = we; mem_byte = byt; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!sram_oe_n) oe_c++;
            if (!sram_ce_n) ad_s = sram_addr;
            if (!sram_we_n) begin
                we_c++; be_s = sram_be_n; wd_s = sram_wdata;
            end
            if (use_mem ? mem_done : if_done) begin
                lat = i;
                break;
            end
        end
        mem_req = 1'b0;
        if_req  = 1'b0;
    endtask

    int          lat, oe_c, we_c, k, m_cnt, i_cnt;
    logic [3:0]  be_s;
    logic [31:0] wd_s;
    logic [19:0] ad_s;
    logic [7:0]  seq, seq_exp;
    logic        seen;

    initial begin
        rst = 1'b0; if_req = 0; mem_req = 0; mem_we = 0; mem_byte = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; sram_rdata = 0;
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b1;

        // IF word read
        sram_rdata = 32'hDEADBEEF;
        run_txn(0, 0, 0, 32'h0000_0010, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("if_lat", lat, 2);
        chk("if_oe_cycles", oe_c, 1);
        chk("if_addr", {12'h0, ad_s}, 32'h4);
        chk("if_rdata", if_rdata, 32'hDEADBEEF);
        chk("if_mem_rdata_hold", mem_rdata, 32'h0);
        @(negedge clk);
        chk("if_done_one_cycle", {31'h0, if_done}, 32'h0);

        // SB lane 3
        run_txn(1, 1, 1, 32'h0000_0103, 32'h0000_00A5, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("sb_lat", lat, 3);
        chk("sb_we_cycles", we_c, 1);
        chk("sb_be_n", {28'h0, be_s}, 32'h7);
        chk("sb_wdata", wd_s, 32'hA5A5A5A5);
        chk("sb_addr", {12'h0, ad_s}, 32'h40);
        chk("sb_hold", {29'h0, sram_we_n, sram_ce_n, sram_data_oe}, 32'h5);

        // SW word
        run_txn(1, 1, 0, 32'h0000_0009, 32'h12345678, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("sw_lat", lat, 3);
        chk("sw_be_n", {28'h0, be_s}, 32'h0);
        chk("sw_wdata", wd_s, 32'h12345678);
        chk("sw_addr", {12'h0, ad_s}, 32'h2);

        // Loads: LB sign-extended lanes, LW ignores addr[1:0]
        sram_rdata = 32'h1280FF00;
        run_txn(1, 0, 1, 32'h0000_0002, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("lb2_lat", lat, 2);
        chk("lb2_rdata", mem_rdata, 32'hFFFFFF80);
        run_txn(1, 0, 0, 32'h0000_0002, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("lw_rdata", mem_rdata, 32'h1280FF00);
        run_txn(1, 0, 1, 32'h0000_0003, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("lb3_rdata", mem_rdata, 32'h00000012);
        run_txn(1, 0, 1, 32'h0000_0001, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("lb1_rdata", mem_rdata, 32'hFFFFFFFF);
        chk("if_rdata_hold", if_rdata, 32'hDEADBEEF);

        // Upper address bits wrap
        sram_rdata = 32'hCAFEF00D;
        run_txn(0, 0, 0, 32'hFFC0_0010, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("wrap_addr", {12'h0, ad_s}, 32'h4);
        chk("wrap_rdata", if_rdata, 32'hCAFEF00D);
        chk("wrap_mem_hold", mem_rdata, 32'hFFFFFFFF);

        // Asynchronous reset in the middle of a read
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h0000_0020;
        @(negedge clk);
        chk("mid_rd_oe", {31'h0, sram_oe_n}, 32'h0);
        #2 rst = 1'b0; if_req = 1'b0;
        #1 chk_reset("rst_mid");
        @(negedge clk);
        rst = 1'b1;

        // Simultaneous requests, four from each port
        @(negedge clk);
        sram_rdata = 32'h0; mem_we = 0; mem_byte = 0; mem_addr = 32'h20; if_addr = 32'h40;
        mem_req = 1'b1; if_req = 1'b1;
        k = 0; m_cnt = 0; i_cnt = 0; seq = 8'h0;
        for (int c = 0; c < 60 && k < 8; c++) begin
            @(negedge clk);
            if (mem_done) begin
                seq[k] = 1'b1; k++; m_cnt++;
                if (m_cnt == 4) mem_req = 1'b0;
            end
            if (if_done) begin
                seq[k] = 1'b0; k++; i_cnt++;
                if (i_cnt == 4) if_req = 1'b0;
            end
        end
        mem_req = 1'b0; if_req = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        seq_exp = 8'b0101_0101;
`else
        seq_exp = 8'b0000_1111;
`endif
        chk("arb_count", k, 8);
        chk("arb_order", {24'h0, seq}, {24'h0, seq_exp});

        // Reset during the write pulse
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_byte = 1'b0; mem_addr = 32'h30; mem_wdata = 32'h55AA55AA;
        @(negedge clk);
        chk("wr_setup", {30'h0, sram_we_n, sram_data_oe}, 32'h3);
        @(negedge clk);
        chk("wr_pulse_we", {31'h0, sram_we_n}, 32'h0);
        #2 rst = 1'b0; mem_req = 1'b0;
        #1 chk("rst_wr_strobes", {29'h0, sram_we_n, sram_ce_n, sram_data_oe}, 32'h6);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_done || !sram_ce_n) seen = 1'b1;
        end
        chk("rst_wr_no_done", {31'h0, seen}, 32'h0);

        // Recovery after reset
        sram_rdata = 32'h0BADC0DE;
        run_txn(0, 0, 0, 32'h0000_0100, 0, lat, oe_c, we_c, be_s, wd_s, ad_s);
        chk("recover_lat", lat, 2);
        chk("recover_rdata", if_rdata, 32'h0BADC0DE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
